// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared helpers for the sequence detector family
package seq_det_pkg;

    localparam int MAX_PAT_W    = 64;
    localparam int MAX_PAT_BITS = 1024;

    function automatic int fill_width(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

    // Pattern idx occupies patterns[idx*pat_len +: pat_len]; callers truncate to their PAT_LEN.
    function automatic logic [MAX_PAT_W-1:0] get_pat(input logic [MAX_PAT_BITS-1:0] patterns,
                                                     input int idx,
                                                     input int pat_len);
        logic [MAX_PAT_W-1:0] pat;
        pat = '0;
        for (int b = 0; b < MAX_PAT_W; b++) begin
            if (b < pat_len && (idx * pat_len + b) < MAX_PAT_BITS) begin
                pat[b] = patterns[idx * pat_len + b];
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/moore_multi_seq_detector.sv
// rtl/moore_multi_seq_detector.sv - Moore detector for NUM_PAT programmable serial patterns
module moore_multi_seq_detector
    import seq_det_pkg::*;
#(
    parameter int                          PAT_LEN  = 2,
    parameter int                          NUM_PAT  = 2,
    parameter logic [PAT_LEN*NUM_PAT-1:0]  PATTERNS = 4'b1001,
    parameter int                          OVERLAP  = 1,
    parameter int                          CNT_W    = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             clr,
    input  logic                             x,
    output logic [NUM_PAT-1:0]               match_vec,
    output logic                             y,
    output logic [fill_width(PAT_LEN)-1:0]   fill,
    output logic [CNT_W-1:0]                 match_cnt
);

    localparam int FILL_W = fill_width(PAT_LEN);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] history_q;
    logic [PAT_LEN-1:0] history_d;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_d;
    logic [NUM_PAT-1:0] cur_hit;
    logic [NUM_PAT-1:0] nxt_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            history_q <= '0;
            fill_q    <= '0;
        end else if (clr) begin
            history_q <= '0;
            fill_q    <= '0;
        end else if (en) begin
            history_q <= history_d;
            fill_q    <= fill_d;
        end
    end

    // Without overlap a matching state throws its history away and keeps only the new bit.
    always_comb begin
        history_d = PAT_LEN'({history_q, x});
        fill_d    = (fill_q == FULL) ? fill_q : fill_q + FILL_W'(1);
        if (OVERLAP == 0 && y) begin
            history_d    = '0;
            history_d[0] = x;
            fill_d       = FILL_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_PAT; i++) begin : g_cmp
        localparam logic [PAT_LEN-1:0] PAT = PAT_LEN'(get_pat(MAX_PAT_BITS'(PATTERNS), i, PAT_LEN));
        assign cur_hit[i] = (fill_q == FULL) && (history_q == PAT);
        assign nxt_hit[i] = (fill_d == FULL) && (history_d == PAT);
    end

    always_comb begin
        match_vec = cur_hit;
        y         = |cur_hit;
        fill      = fill_q;
    end

    // One count per enabled edge that lands in a matching state, however many patterns hit.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (en && !clr && (|nxt_hit)),
        .count (match_cnt)
    );

endmodule

// File: tb/tb_moore_multi_seq_detector.sv
// tb/tb_moore_multi_seq_detector.sv - scoreboard bench for moore_multi_seq_detector
module tb_moore_multi_seq_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v = 3'b000;
    logic [2:0] en_v  = 3'b000;
    logic [2:0] clr_v = 3'b000;
    logic [2:0] x_v   = 3'b000;

    logic [1:0] vec_a, vec_b;
    logic [0:0] vec_c;
    logic       y_a, y_b, y_c;
    logic [1:0] fill_a, fill_b;
    logic [2:0] fill_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    moore_multi_seq_detector #(.OVERLAP(1)) dut_a (
        .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .clr(clr_v[0]), .x(x_v[0]),
        .match_vec(vec_a), .y(y_a), .fill(fill_a), .match_cnt(cnt_a));

    moore_multi_seq_detector #(.OVERLAP(0)) dut_b (
        .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .clr(clr_v[1]), .x(x_v[1]),
        .match_vec(vec_b), .y(y_b), .fill(fill_b), .match_cnt(cnt_b));

    moore_multi_seq_detector #(.PAT_LEN(4), .NUM_PAT(1), .PATTERNS(4'b1011), .OVERLAP(1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .clr(clr_v[2]), .x(x_v[2]),
        .match_vec(vec_c), .y(y_c), .fill(fill_c), .match_cnt(cnt_c));

    typedef struct {
        int         id;
        int         due;
        logic [1:0] vec;
        logic       y;
        logic [2:0] fill;
        logic [7:0] cnt;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    int t2_x[9] = '{0, 0, 1, 0, 1, 0, 1, 1, 0};
    int t2_v[9] = '{0, 0, 1, 2, 1, 2, 1, 0, 2};
    int t2_f[9] = '{1, 2, 2, 2, 2, 2, 2, 2, 2};
    int t2_c[9] = '{0, 0, 1, 2, 3, 4, 5, 5, 6};
    int t3_v[9] = '{0, 0, 1, 0, 1, 0, 1, 0, 2};
    int t3_f[9] = '{1, 2, 2, 1, 2, 1, 2, 1, 2};
    int t3_c[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 4};
    int t5_x[16] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
    int t5_v[16] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    int t5_f[16] = '{1, 2, 3, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
    int t5_c[16] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3};
    // id, rst, en, clr, x, vec, fill, cnt for the en-gating / clr / rst sequence on dut_a
    int t4[14][8] = '{
        '{0, 1, 1, 1, 1, 0, 0, 0},
        '{0, 1, 1, 0, 0, 0, 1, 0},
        '{0, 1, 1, 0, 1, 1, 2, 1},
        '{0, 1, 0, 0, 0, 1, 2, 1},
        '{0, 1, 0, 0, 0, 1, 2, 1},
        '{0, 1, 0, 0, 0, 1, 2, 1},
        '{0, 1, 1, 0, 0, 2, 2, 2},
        '{0, 1, 1, 1, 1, 0, 0, 0},
        '{0, 1, 1, 0, 0, 0, 1, 0},
        '{0, 1, 1, 0, 1, 1, 2, 1},
        '{0, 1, 1, 0, 0, 2, 2, 2},
        '{0, 1, 1, 0, 1, 1, 2, 3},
        '{0, 1, 1, 0, 0, 2, 2, 4},
        '{0, 1, 1, 0, 1, 1, 2, 5}
    };

    task automatic compare(input string tag, input int id, input logic [1:0] ev, input logic ey,
                           input logic [2:0] ef, input logic [7:0] ec);
        logic [1:0] av;
        logic       ay;
        logic [2:0] af;
        logic [7:0] ac;
        case (id)
            0:       begin av = vec_a;         ay = y_a; af = {1'b0, fill_a}; ac = cnt_a;         end
            1:       begin av = vec_b;         ay = y_b; af = {1'b0, fill_b}; ac = cnt_b;         end
            default: begin av = {1'b0, vec_c}; ay = y_c; af = fill_c;         ac = {6'b0, cnt_c}; end
        endcase
        n_tests++;
        if ({av, ay, af, ac} !== {ev, ey, ef, ec}) begin
            n_fail++;
            $display("FAIL %s dut%0d: got vec=%b y=%b fill=%0d cnt=%0d, want vec=%b y=%b fill=%0d cnt=%0d",
                     tag, id, av, ay, af, ac, ev, ey, ef, ec);
        end
    endtask

    task automatic step(input int id, input int r, input int e, input int c, input int xv,
                        input int ev, input int ef, input int ec, input string tag);
        exp_t ex;
        @(negedge clk);
        #1;
        rst_v[id] = r[0];
        en_v[id]  = e[0];
        clr_v[id] = c[0];
        x_v[id]   = xv[0];
        ex.id   = id;
        ex.due  = cyc + 1;
        ex.vec  = ev[1:0];
        ex.y    = |ev[1:0];
        ex.fill = ef[2:0];
        ex.cnt  = ec[7:0];
        ex.tag  = tag;
        sb_q.push_back(ex);
    endtask

    initial begin : monitor
        exp_t ex;
        forever begin
            @(negedge clk);
            cyc++;
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                ex = sb_q.pop_front();
                compare(ex.tag, ex.id, ex.vec, ex.y, ex.fill, ex.cnt);
            end
        end
    end

    initial begin : stimulus
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, i % 2, 0, 0, 0, $sformatf("reset_s%0d", i));
        step(1, 0, 1, 0, 1, 0, 0, 0, "reset_b");

        for (int i = 0; i < 9; i++) step(0, 1, 1, 0, t2_x[i], t2_v[i], t2_f[i], t2_c[i], $sformatf("ovl_s%0d", i + 1));
        for (int i = 0; i < 9; i++) step(1, 1, 1, 0, t2_x[i], t3_v[i], t3_f[i], t3_c[i], $sformatf("novl_s%0d", i + 1));

        for (int i = 0; i < 10; i++)
            step(t4[i][0], t4[i][1], t4[i][2], t4[i][3], t4[i][4], t4[i][5], t4[i][6], t4[i][7], $sformatf("gate_clr_%0d", i));

        // Mid-stream async reset must clear outputs before any clock edge.
        @(negedge clk);
        #1;
        rst_v[0] = 1'b0;
        #1;
        compare("rst_async", 0, 2'b00, 1'b0, 3'd0, 8'd0);
        step(0, 0, 1, 0, 1, 0, 0, 0, "rst_held");
        step(0, 1, 1, 0, 1, 0, 1, 0, "rst_rel_s1");
        step(0, 1, 1, 0, 0, 2, 2, 1, "rst_rel_s2");

        for (int i = 0; i < 16; i++) step(2, 1, 1, 0, t5_x[i], t5_v[i], t5_f[i], t5_c[i], $sformatf("len4_s%0d", i + 1));

        for (int i = 0; i < 6 && sb_q.size() > 0; i++) begin
            @(negedge clk);
            #2;
        end
        if (sb_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected responses left, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
